// File: rtl/branch_history_table_pkg.sv
// Shared predictor definitions: forcer encodings, prediction constants and
// sizing helpers used by the branch history table and its interface.
package branch_history_table_pkg;

    typedef enum logic [1:0] {
        FORCE_NT     = 2'b00,
        FORCE_TBL_LO = 2'b01,
        FORCE_TBL_HI = 2'b10,
        FORCE_T      = 2'b11
    } force_e;

    localparam logic HIT  = 1'b1;
    localparam logic MISS = 1'b0;

    // Weakly-not-taken starting value: one below the taken threshold.
    function automatic int unsigned ctr_init(input int unsigned ctr_bits);
        return (32'd1 << (ctr_bits - 1)) - 32'd1;
    endfunction

    function automatic int unsigned ghr_width(input int unsigned ghr_bits);
        return (ghr_bits == 0) ? 1 : ghr_bits;
    endfunction

endpackage

// File: rtl/branch_history_table_if.sv
// Fetch-side prediction and execute-side resolution signals of the branch
// history table; master is the pipeline, slave is the predictor.
interface branch_history_table_if
    import branch_history_table_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned GHR_BITS   = 0
);
    localparam int unsigned GW = ghr_width(GHR_BITS);

    logic [31:0]           pred_pc;
    logic [1:0]            forcer;
    logic                  pred_taken;
    logic [INDEX_BITS-1:0] pred_index;
    logic                  upd_valid;
    logic [INDEX_BITS-1:0] upd_index;
    logic                  upd_taken;
    logic [GW-1:0]         ghr_out;

    modport master (
        output pred_pc, forcer, upd_valid, upd_index, upd_taken,
        input  pred_taken, pred_index, ghr_out
    );

    modport slave (
        input  pred_pc, forcer, upd_valid, upd_index, upd_taken,
        output pred_taken, pred_index, ghr_out
    );

endinterface

// File: rtl/branch_history_table_sat_counter.sv
// One saturating up/down counter of the prediction table; resets to the
// weakly-not-taken value and never wraps.
module branch_history_table_sat_counter
    import branch_history_table_pkg::*;
#(
    parameter int unsigned CTR_BITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inc,
    input  logic                dec,
    output logic [CTR_BITS-1:0] ctr
);
    localparam logic [CTR_BITS-1:0] INIT = CTR_BITS'(ctr_init(CTR_BITS));
    localparam logic [CTR_BITS-1:0] MAX  = '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            ctr <= INIT;
        end else if (inc && (ctr != MAX)) begin
            ctr <= ctr + 1'b1;
        end else if (dec && (ctr != '0)) begin
            ctr <= ctr - 1'b1;
        end
    end

endmodule

// File: rtl/branch_history_table.sv
// Per-PC branch predictor: table of saturating counters indexed by the fetch
// PC, optionally XOR-hashed with non-speculative global history (gshare).
module branch_history_table
    import branch_history_table_pkg::*;
#(
    parameter int unsigned CTR_BITS   = 2,
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned GHR_BITS   = 0,
    parameter int unsigned PC_LSB     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    branch_history_table_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << INDEX_BITS;
    localparam int unsigned GW    = ghr_width(GHR_BITS);

    logic [CTR_BITS-1:0]   ctr [DEPTH];
    logic [GW-1:0]         ghr;
    logic [INDEX_BITS-1:0] raw_index;
    logic [INDEX_BITS-1:0] index;
    logic [CTR_BITS-1:0]   ctr_sel;
    logic                  table_taken;
    logic                  unused_pc;

    // Only the indexing slice of the PC matters; the rest is folded away.
    assign unused_pc = ^bus.pred_pc;

    assign raw_index = bus.pred_pc[PC_LSB +: INDEX_BITS];
    assign index     = raw_index ^ INDEX_BITS'(ghr);

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic hit;
        assign hit = bus.upd_valid && (bus.upd_index == INDEX_BITS'(i));

        branch_history_table_sat_counter #(
            .CTR_BITS(CTR_BITS)
        ) u_ctr (
            .clk (clk),
            .rst (rst),
            .inc (hit && bus.upd_taken),
            .dec (hit && !bus.upd_taken),
            .ctr (ctr[i])
        );
    end

    // History shifts in resolved outcomes only, so it never needs repair.
    if (GHR_BITS == 0) begin : g_bimodal
        assign ghr = '0;
    end else if (GHR_BITS == 1) begin : g_ghr1
        always_ff @(posedge clk) begin
            if (rst) begin
                ghr <= '0;
            end else if (bus.upd_valid) begin
                ghr <= bus.upd_taken;
            end
        end
    end else begin : g_ghrn
        always_ff @(posedge clk) begin
            if (rst) begin
                ghr <= '0;
            end else if (bus.upd_valid) begin
                ghr <= {ghr[GHR_BITS-2:0], bus.upd_taken};
            end
        end
    end

    assign ctr_sel     = ctr[index];
    assign table_taken = ctr_sel[CTR_BITS-1];

    always_comb begin
        bus.pred_taken = table_taken;
        case (force_e'(bus.forcer))
            FORCE_NT: bus.pred_taken = MISS;
            FORCE_T:  bus.pred_taken = HIT;
            default:  bus.pred_taken = table_taken;
        endcase
    end

    assign bus.pred_index = index;
    assign bus.ghr_out    = ghr;

endmodule

// File: tb/tb_branch_history_table.sv
// Self-checking bench: a bimodal and a gshare predictor side by side, driven
// by directed vectors, hand sequences and random traffic against a model.
module tb_branch_history_table;

    logic clk;
    logic rst;

    int checks   = 0;
    int failures = 0;

    int b_ctr [64];
    int g_ctr [64];
    int g_ghr;

    branch_history_table_if #(.INDEX_BITS(6), .GHR_BITS(0)) b_if ();
    branch_history_table_if #(.INDEX_BITS(6), .GHR_BITS(4)) g_if ();

    branch_history_table #(
        .CTR_BITS(2), .INDEX_BITS(6), .GHR_BITS(0), .PC_LSB(2)
    ) u_bimodal (
        .clk (clk),
        .rst (rst),
        .bus (b_if.slave)
    );

    branch_history_table #(
        .CTR_BITS(2), .INDEX_BITS(6), .GHR_BITS(4), .PC_LSB(2)
    ) u_gshare (
        .clk (clk),
        .rst (rst),
        .bus (g_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  forcer;
        logic        uv;
        logic [5:0]  ui;
        logic        ut;
        logic        exp_taken;
        logic [5:0]  exp_index;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int sat(input int v, input logic up);
        if (up) return (v >= 3) ? 3 : v + 1;
        return (v <= 0) ? 0 : v - 1;
    endfunction

    function automatic logic model_pred(input logic [1:0] f, input int c);
        if (f == 2'b00) return 1'b0;
        if (f == 2'b11) return 1'b1;
        return (c >= 2);
    endfunction

    // Commits whatever the bench held on the inputs across this clock edge.
    task automatic model_apply();
        if (rst) begin
            for (int i = 0; i < 64; i++) begin
                b_ctr[i] = 1;
                g_ctr[i] = 1;
            end
            g_ghr = 0;
        end else begin
            if (b_if.upd_valid)
                b_ctr[b_if.upd_index] = sat(b_ctr[b_if.upd_index], b_if.upd_taken);
            if (g_if.upd_valid) begin
                g_ctr[g_if.upd_index] = sat(g_ctr[g_if.upd_index], g_if.upd_taken);
                g_ghr = ((g_ghr << 1) | int'(g_if.upd_taken)) & 15;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_apply();
        #1;
    endtask

    task automatic idle_inputs();
        b_if.pred_pc = '0; b_if.forcer = 2'b01; b_if.upd_valid = 1'b0;
        b_if.upd_index = '0; b_if.upd_taken = 1'b0;
        g_if.pred_pc = '0; g_if.forcer = 2'b01; g_if.upd_valid = 1'b0;
        g_if.upd_index = '0; g_if.upd_taken = 1'b0;
    endtask

    task automatic check_models();
        int bidx;
        int gidx;
        bidx = int'((b_if.pred_pc >> 2) & 32'd63);
        gidx = int'((g_if.pred_pc >> 2) & 32'd63) ^ g_ghr;
        check("rnd_b_index", b_if.pred_index, bidx);
        check("rnd_b_taken", b_if.pred_taken, model_pred(b_if.forcer, b_ctr[bidx]));
        check("rnd_b_ghr",   b_if.ghr_out, 0);
        check("rnd_g_index", g_if.pred_index, gidx);
        check("rnd_g_taken", g_if.pred_taken, model_pred(g_if.forcer, g_ctr[gidx]));
        check("rnd_g_ghr",   g_if.ghr_out, g_ghr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        logic [3:0] outcomes;

        //              pc            f      uv    ui    ut    taken idx
        vecs[0]  = '{32'h0000_0014, 2'b01, 1'b1, 6'd5, 1'b1, 1'b0, 6'd5};
        vecs[1]  = '{32'h0000_0014, 2'b01, 1'b1, 6'd5, 1'b1, 1'b1, 6'd5};
        vecs[2]  = '{32'h0000_0014, 2'b01, 1'b1, 6'd5, 1'b1, 1'b1, 6'd5};
        vecs[3]  = '{32'h0000_0014, 2'b01, 1'b1, 6'd5, 1'b1, 1'b1, 6'd5};
        vecs[4]  = '{32'h0000_0014, 2'b01, 1'b1, 6'd5, 1'b0, 1'b1, 6'd5};
        vecs[5]  = '{32'h0000_0014, 2'b01, 1'b1, 6'd5, 1'b0, 1'b1, 6'd5};
        vecs[6]  = '{32'h0000_0014, 2'b01, 1'b1, 6'd5, 1'b0, 1'b0, 6'd5};
        vecs[7]  = '{32'h0000_0014, 2'b01, 1'b1, 6'd5, 1'b0, 1'b0, 6'd5};
        vecs[8]  = '{32'h0000_0014, 2'b11, 1'b0, 6'd0, 1'b0, 1'b1, 6'd5};
        vecs[9]  = '{32'h0000_0014, 2'b10, 1'b1, 6'd5, 1'b1, 1'b0, 6'd5};
        vecs[10] = '{32'h0000_0114, 2'b01, 1'b1, 6'd5, 1'b1, 1'b0, 6'd5};
        vecs[11] = '{32'h0000_0114, 2'b01, 1'b0, 6'd0, 1'b0, 1'b1, 6'd5};
        vecs[12] = '{32'h0000_0018, 2'b01, 1'b0, 6'd0, 1'b0, 1'b0, 6'd6};
        vecs[13] = '{32'h0000_0014, 2'b00, 1'b1, 6'd5, 1'b1, 1'b0, 6'd5};
        vecs[14] = '{32'h0000_0014, 2'b01, 1'b0, 6'd0, 1'b0, 1'b1, 6'd5};
        vecs[15] = '{32'hFFFF_FF14, 2'b01, 1'b0, 6'd0, 1'b0, 1'b1, 6'd5};

        rst = 1'b1;
        idle_inputs();
        tick();
        rst = 1'b0;

        // Every entry starts weakly not-taken with empty history.
        for (int i = 0; i < 64; i++) begin
            b_if.pred_pc = 32'(i * 4);
            g_if.pred_pc = 32'(i * 4);
            #2;
            check("rst_b_taken", b_if.pred_taken, 0);
            check("rst_b_index", b_if.pred_index, i);
            check("rst_g_taken", g_if.pred_taken, 0);
            check("rst_g_index", g_if.pred_index, i);
            tick();
        end
        check("rst_b_ghr", b_if.ghr_out, 0);
        check("rst_g_ghr", g_if.ghr_out, 0);

        b_if.pred_pc = 32'h14;
        b_if.forcer  = 2'b11;
        #2;
        check("force_t_after_rst", b_if.pred_taken, 1);
        tick();

        for (int r = 0; r < 16; r++) begin
            b_if.pred_pc   = vecs[r].pc;
            b_if.forcer    = vecs[r].forcer;
            b_if.upd_valid = vecs[r].uv;
            b_if.upd_index = vecs[r].ui;
            b_if.upd_taken = vecs[r].ut;
            #2;
            check("vec_taken", b_if.pred_taken, vecs[r].exp_taken);
            check("vec_index", b_if.pred_index, vecs[r].exp_index);
            check("vec_ghr",   b_if.ghr_out, 0);
            tick();
        end
        idle_inputs();

        // gshare history: outcomes 1,0,1,1 give 4'b1011.
        outcomes = 4'b1011;
        for (int k = 3; k >= 0; k--) begin
            g_if.upd_valid = 1'b1;
            g_if.upd_index = 6'd0;
            g_if.upd_taken = outcomes[k];
            #2;
            tick();
        end
        g_if.upd_valid = 1'b0;
        g_if.pred_pc   = 32'h14;
        #2;
        check("gshare_ghr",   g_if.ghr_out, 4'b1011);
        check("gshare_index", g_if.pred_index, 6'd14);
        check("gshare_taken", g_if.pred_taken, 0);
        tick();

        // Reset wins over a simultaneous update of a saturated entry.
        rst            = 1'b1;
        b_if.pred_pc   = 32'h14;
        b_if.upd_valid = 1'b1;
        b_if.upd_index = 6'd5;
        b_if.upd_taken = 1'b1;
        #2;
        tick();
        rst            = 1'b0;
        b_if.upd_valid = 1'b0;
        #2;
        check("rst_upd_taken", b_if.pred_taken, 0);
        check("rst_upd_ghr",   g_if.ghr_out, 0);
        tick();
        b_if.upd_valid = 1'b1;
        #2;
        check("rst_upd_same_cycle", b_if.pred_taken, 0);
        tick();
        b_if.upd_valid = 1'b0;
        #2;
        check("rst_upd_next_cycle", b_if.pred_taken, 1);
        tick();

        for (int n = 0; n < 400; n++) begin
            rst            = ($urandom_range(0, 39) == 0);
            b_if.pred_pc   = $urandom;
            b_if.forcer    = 2'($urandom_range(0, 3));
            b_if.upd_valid = 1'($urandom_range(0, 1));
            b_if.upd_index = 6'($urandom_range(0, 7));
            b_if.upd_taken = 1'($urandom_range(0, 1));
            g_if.pred_pc   = $urandom;
            g_if.forcer    = 2'($urandom_range(0, 3));
            g_if.upd_valid = 1'($urandom_range(0, 1));
            g_if.upd_index = 6'($urandom_range(0, 63));
            g_if.upd_taken = 1'($urandom_range(0, 1));
            #2;
            check_models();
            tick();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_history_table.md
Name: branch_history_table

Overview:
- Per-branch predictor: table of 2^INDEX_BITS saturating counters indexed by fetch PC, optionally hashed with a global history register (gshare).
- Sits beside PCSel in fetch: a combinational taken/not-taken prediction goes out each cycle.
- The resolved outcome comes back from the branch checker in execute, together with the index used at predict time.
- Successor to the single-counter predictor: per-PC state, selectable bimodal/gshare mode, explicit weak-state initialisation, retained force override.

Parameters:
- CTR_BITS, 2, width of each saturating counter (>=1).
- INDEX_BITS, 6, log2 of table depth (64 entries).
- GHR_BITS, 0, global history length; 0 = bimodal, 1..INDEX_BITS = gshare.
- PC_LSB, 2, lowest PC bit used for indexing (word-aligned instructions).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- pred_pc  in  32  PC of the instruction in fetch.
- forcer  in  2  00 = force not-taken, 11 = force taken, 01/10 = use table.
- pred_taken  out  1  prediction for pred_pc.
- pred_index  out  INDEX_BITS  table index used for this prediction; the pipeline carries it to execute.
- upd_valid  in  1  a branch resolved this cycle.
- upd_index  in  INDEX_BITS  pred_index captured at fetch for that branch.
- upd_taken  in  1  actual branch outcome.
- ghr_out  out  max(GHR_BITS,1)  current global history; 0 when GHR_BITS=0; debug/verification only.

Behaviour:
- Reset:
  - Synchronous; on a rising edge with rst=1, every counter loads INIT = 2^(CTR_BITS-1)-1 (weakly not-taken) and ghr loads 0.
  - rst dominates a simultaneous upd_valid.
  - Reset mid-operation discards all history; no in-flight update is retained.
  - Outputs after reset: pred_taken=0 unless forcer=11; pred_index = hash of pred_pc; ghr_out=0.
- Indexing (combinational):
  - raw = pred_pc[PC_LSB+INDEX_BITS-1 : PC_LSB].
  - If GHR_BITS=0: pred_index = raw.
  - Otherwise pred_index = raw XOR zero-extended ghr (ghr in the low bits).
- Prediction:
  - Zero-latency combinational read of the registered table.
  - pred_taken = (ctr[pred_index] >= 2^(CTR_BITS-1)).
  - forcer 00 overrides to 0; forcer 11 overrides to 1. pred_index is still driven under force.
- Update (one rising edge after upd_valid=1 and rst=0):
  - upd_taken=1: ctr[upd_index] increments, saturating at 2^CTR_BITS-1.
  - upd_taken=0: ctr[upd_index] decrements, saturating at 0.
  - No wrap-around in either direction.
  - When GHR_BITS>0: ghr <= {ghr[GHR_BITS-2:0], upd_taken}, i.e. history is non-speculative and updated at resolution only. For GHR_BITS=1, ghr <= upd_taken.
  - upd_valid=0: table and ghr hold.
- Simultaneous read/write, same index: the prediction in that cycle uses the pre-update value (no bypass). The new value is visible from the next cycle.
- forcer does not gate updates; training continues while forced.
- Only one update per cycle; the pipeline guarantees this.
- Width rules: counters are unsigned CTR_BITS; the index hash is INDEX_BITS wide; the PC slice is truncated and no bits above it are used.

Decomposition:
- Shared predictor package holds:
  - forcer encodings FORCE_NT=2'b00, FORCE_T=2'b11.
  - the HIT/MISS constants.
  - helper function ctr_init(CTR_BITS).
- One natural sub-module, sat_counter: parametrised CTR_BITS, with inc/dec/hold inputs and saturation. It is instantiated per entry via generate, or its logic is reused as a function on the array.
- GHR and index hash live in the top.

Test Plan:
1. Reset, CTR_BITS=2: rst=1 for 1 cycle, sweep pred_pc 0x00..0xFC -> pred_taken=0 for all 64 indices, ghr_out=0.
2. Saturation up: upd_valid=1, upd_index=5, upd_taken=1 for 4 cycles -> counter goes 1,2,3,3; pred_taken at pred_pc=0x14 becomes 1 after the first update and stays 1. Then 3 not-taken updates -> 2,1,0, pred_taken=0; a 4th holds at 0.
3. Aliasing/isolation: train index 5 to taken -> pred_pc=0x114 predicts taken (same raw index); pred_pc=0x18 (index 6) stays not-taken.
4. Same-cycle read/write, index 5 at value 1: pred_pc=0x14 with upd_index=5, upd_taken=1 -> pred_taken=0 that cycle, 1 the next.
5. gshare, GHR_BITS=4: updates with outcomes 1,0,1,1 -> ghr_out=4'b1011. pred_pc=0x14 -> pred_index=5^11=14.
6. forcer=11 after reset -> pred_taken=1. forcer=00 with index 5 saturated -> pred_taken=0. Updates under force still move the counters. rst asserted together with upd_valid -> counter returns to 1.
